// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register with PC+4 / branch-redirect select and the IF/ID
// pipeline register, driven by the hazard unit's stall controls and the ID-stage branch flush.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        PCWrite_i,
  input  logic        Stall_i,
  input  logic        Flush_i,
  input  logic [31:0] branch_target_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o,
  output logic        misalign_o,
  output logic [31:0] fetch_cnt_o
);

  logic [31:0] pc_q,       pc_d;
  logic [31:0] id_pc_q,    id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] pc_plus4;

  // Wraps naturally modulo 2^32; alignment is preserved since PC[1:0] is always 00.
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    // NOTE: every signal gets a hold default first so no path through the if/else
    // leaves one unassigned, which would otherwise infer a latch.
    pc_d        = pc_q;
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    id_valid_d  = id_valid_q;
    misalign_d  = misalign_q;
    fetch_cnt_d = fetch_cnt_q;

    if (start_i) begin
      if (Stall_i) begin
        // A flush arriving with a stall is dropped; the branch re-resolves next cycle.
        if (PCWrite_i) pc_d = pc_plus4;
      end else if (Flush_i) begin
        pc_d       = {branch_target_i[31:2], 2'b00};
        id_pc_d    = pc_q;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
        if (branch_target_i[1:0] != 2'b00) misalign_d = 1'b1;
      end else begin
        id_pc_d     = pc_q;
        id_instr_d  = instr_i;
        id_valid_d  = 1'b1;
        fetch_cnt_d = fetch_cnt_q + 32'd1;
        if (PCWrite_i) pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q        <= RESET_PC;
      id_pc_q     <= 32'h0000_0000;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= 32'h0000_0000;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // independent of statement order.
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign instr_addr_o = pc_q;
  assign pc_o         = id_pc_q;
  assign instr_o      = id_instr_q;
  assign valid_o      = id_valid_q;
  assign misalign_o   = misalign_q;
  assign fetch_cnt_o  = fetch_cnt_q;

endmodule
